// File: rtl/uart_tx_fifo.sv
// UART transmitter with a TX FIFO.
// Frame config is latched at each START so mid-frame changes stay out.
module uart_tx_fifo #(
  parameter int C_CLK_FREQ   = 100000000,
  parameter int C_DIV_WIDTH  = 16,
  parameter int C_FIFO_DEPTH = 16
) (
  input  logic                           I_clk,
  input  logic                           I_rst,
  input  logic [C_DIV_WIDTH-1:0]         I_baud_div,
  input  logic [3:0]                     I_cfg_width,
  input  logic [2:0]                     I_cfg_parity,
  input  logic [1:0]                     I_cfg_stop,
  input  logic                           I_cfg_msb,
  input  logic                           I_break,
  input  logic [8:0]                     I_data,
  input  logic                           I_data_v,
  output logic                           O_data_ready,
  output logic                           O_tx,
  output logic                           O_busy,
  output logic [$clog2(C_FIFO_DEPTH):0]  O_fifo_level,
  output logic                           O_overflow
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int DW = C_DIV_WIDTH;
  localparam int CW = C_DIV_WIDTH + 2;

  if (C_FIFO_DEPTH < 2 || C_FIFO_DEPTH > 256 ||
      (C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0 ||
      C_DIV_WIDTH < 2 || C_CLK_FREQ < 1) begin : g_bad_cfg
    $error("uart_tx_fifo: bad parameters");
  end

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BREAK
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    mem_q [C_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          tx_q, tx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    data_q, data_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    width_q, width_d;
  logic          par_en_q, par_en_d;
  logic          par_bit_q, par_bit_d;
  logic [1:0]    stop_q, stop_d;
  logic          msb_q, msb_d;
  logic          brk_hi_q, brk_hi_d;

  logic          full, empty, push, pop;
  logic          go_start, cnt_zero;
  logic [8:0]    rdata, mask_in, masked;
  logic [DW-1:0] div_in;
  logic [3:0]    width_in, idx;
  logic [CW-1:0] per, stop_cnt;

  assign full     = level_q == (AW+1)'(C_FIFO_DEPTH);
  assign empty    = level_q == '0;
  assign push     = I_data_v && !full;
  assign rdata    = mem_q[rd_ptr_q];
  assign cnt_zero = cnt_q == '0;

  // Clamped view of the live config, used only when a frame starts.
  always_comb begin
    div_in = I_baud_div;
    if (I_baud_div < DW'(3)) div_in = DW'(3);
    width_in = I_cfg_width;
    if (I_cfg_width < 4'd5) width_in = 4'd5;
    if (I_cfg_width > 4'd9) width_in = 4'd9;
  end

  assign mask_in = ~(9'h1FF << width_in);
  assign masked  = rdata & mask_in;

  assign per = CW'(div_q) + CW'(1);
  always_comb begin
    unique case (stop_q)
      2'd0:    stop_cnt = per - CW'(1);
      2'd1:    stop_cnt = per + (per >> 1) - CW'(1);
      default: stop_cnt = (per << 1) - CW'(1);
    endcase
  end

  assign idx = msb_q ? (width_q - 4'd1 - bit_q) : bit_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_zero ? cnt_q : cnt_q - CW'(1);
    bit_d     = bit_q;
    data_d    = data_q;
    div_d     = div_q;
    width_d   = width_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    msb_d     = msb_q;
    brk_hi_d  = brk_hi_q;
    go_start  = 1'b0;
    tx_d      = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (I_break) begin
          state_d  = BREAK;
          brk_hi_d = 1'b0;
          div_d    = div_in;
        end else if (!empty) begin
          go_start = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_zero) begin
          state_d = DATA;
          cnt_d   = CW'(div_q);
          bit_d   = '0;
        end
      end
      DATA: begin
        tx_d = data_q[idx];
        if (cnt_zero) begin
          if (bit_q == width_q - 4'd1) begin
            state_d = par_en_q ? PARITY : STOP;
            cnt_d   = par_en_q ? CW'(div_q) : stop_cnt;
          end else begin
            bit_d = bit_q + 4'd1;
            cnt_d = CW'(div_q);
          end
        end
      end
      PARITY: begin
        tx_d = par_bit_q;
        if (cnt_zero) begin
          state_d = STOP;
          cnt_d   = stop_cnt;
        end
      end
      STOP: begin
        if (cnt_zero) begin
          if (I_break) begin
            state_d  = BREAK;
            brk_hi_d = 1'b0;
            div_d    = div_in;
          end else if (!empty) begin
            go_start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        tx_d = brk_hi_q;
        // Low while requested, then one bit period of mark.
        if (!brk_hi_q) begin
          if (!I_break) begin
            brk_hi_d = 1'b1;
            cnt_d    = CW'(div_q);
          end
        end else if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (go_start) begin
      state_d  = START;
      cnt_d    = CW'(div_in);
      div_d    = div_in;
      width_d  = width_in;
      stop_d   = I_cfg_stop;
      msb_d    = I_cfg_msb;
      data_d   = masked;
      par_en_d = I_cfg_parity inside {3'd1, 3'd2, 3'd3, 3'd4};
      unique case (I_cfg_parity)
        3'd1:    par_bit_d = ^masked;
        3'd2:    par_bit_d = ~^masked;
        3'd3:    par_bit_d = 1'b1;
        default: par_bit_d = 1'b0;
      endcase
    end
  end

  assign pop = go_start;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
    ovf_d    = I_data_v && full;
  end

  always_ff @(posedge I_clk) begin
    if (push && !I_rst) mem_q[wr_ptr_q] <= I_data;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      div_q     <= DW'(3);
      width_q   <= 4'd8;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= '0;
      msb_q     <= 1'b0;
      brk_hi_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      div_q     <= div_d;
      width_q   <= width_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop_q    <= stop_d;
      msb_q     <= msb_d;
      brk_hi_q  <= brk_hi_d;
    end
  end

  assign O_data_ready = !full;
  assign O_tx         = tx_q;
  assign O_busy       = (state_q != IDLE) || !empty;
  assign O_fifo_level = level_q;
  assign O_overflow   = ovf_q;

endmodule
